// File: rtl/led_ctrl_pkg.sv
// Shared constants and types for the LED control button sequencer.
package led_ctrl_pkg;

  // Pattern codes understood by the LED pattern generator
  localparam logic [2:0] PAT_KNIGHT  = 3'd0;
  localparam logic [2:0] PAT_WALK    = 3'd1;
  localparam logic [2:0] PAT_EXPAND  = 3'd2;
  localparam logic [2:0] PAT_BLINK   = 3'd3;
  localparam logic [2:0] PAT_ALT     = 3'd4;
  localparam logic [2:0] PAT_MARQUEE = 3'd5;
  localparam logic [2:0] PAT_SPARKLE = 3'd6;
  localparam logic [2:0] PAT_OFF     = 3'd7;

  // Press classifier state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_LONG = 2'd2;

  // Default timing for a 5 MHz clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 50000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 5000000;
  localparam int unsigned DEF_AUTO_PERIOD       = 25000000;

  // One-cycle press events from a classifier
  typedef struct packed {
    logic short_evt;
    logic long_evt;
  } press_evt_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_ctrl_button_sequencer_btn_debounce.sv
// Per-button synchroniser, debouncer and short/long press classifier.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_raw,
  output press_evt_t o_evt
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_db;
  logic [DB_W-1:0]   r_db_cnt;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic              w_short_c;
  logic              w_long_c;
  press_evt_t        r_evt;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level flips only after an unbroken run of disagreement
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_db     <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync2 != r_db) begin
      if (r_db_cnt == DB_MAX) begin
        r_db     <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Classifier state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Classifier next state and event strobes
  always_comb begin
    w_state_nxt = r_state;
    w_short_c   = 1'b0;
    w_long_c    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_db) w_state_nxt = ST_HELD;
      end
      ST_HELD: begin
        if (!r_db) begin
          w_state_nxt = ST_IDLE;
          w_short_c   = 1'b1;
        end else if (r_hold == HOLD_MAX) begin
          w_state_nxt = ST_LONG;
          w_long_c    = 1'b1;
        end
      end
      ST_LONG: begin
        if (!r_db) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Hold counter: zero while idle, counts while held, saturates at the long threshold
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold <= '0;
    end else if (r_state == ST_IDLE) begin
      r_hold <= '0;
    end else if (r_state == ST_HELD && r_db && r_hold != HOLD_MAX) begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

  // Registered one-cycle events
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_evt <= '0;
    end else begin
      r_evt.short_evt <= w_short_c;
      r_evt.long_evt  <= w_long_c;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/led_ctrl_button_sequencer.sv
// Button front end for the LED pattern generator: pattern, pause and speed commands.
// Optional auto pattern cycling is built when AUTO_CYCLE_EN is defined.
module led_ctrl_button_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
`ifdef AUTO_CYCLE_EN
  ,
  parameter int unsigned AUTO_PERIOD       = DEF_AUTO_PERIOD
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       btn_next_raw,
  input  logic       btn_mode_raw,
  output logic [2:0] pat_sel,
  output logic       speed_sel,
  output logic       pause,
  output logic       auto_active
);

  press_evt_t w_next_evt;
  press_evt_t w_mode_evt;
  logic [2:0] r_pat_sel;
  logic       r_speed_sel;
  logic       r_pause;
  logic       w_adv;

  btn_debounce #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_next (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn_raw(btn_next_raw),
    .o_evt    (w_next_evt)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_mode (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn_raw(btn_mode_raw),
    .o_evt    (w_mode_evt)
  );

`ifdef AUTO_CYCLE_EN
  localparam int unsigned AUTO_W = cnt_width(AUTO_PERIOD);
  localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_PERIOD - 1);

  logic              r_auto_active;
  logic [AUTO_W-1:0] r_auto_timer;
  logic              w_auto_tick;

  assign w_auto_tick = r_auto_active && !r_pause && (r_auto_timer == AUTO_MAX);
  assign w_adv       = w_next_evt.short_evt || w_auto_tick;

  // Auto mode toggle and advance timer; frozen while paused or disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_auto_active <= 1'b0;
      r_auto_timer  <= '0;
    end else if (ena) begin
      if (w_next_evt.long_evt) begin
        r_auto_active <= ~r_auto_active;
        r_auto_timer  <= '0;
      end else if (w_next_evt.short_evt) begin
        r_auto_timer  <= '0;
      end else if (r_auto_active && !r_pause) begin
        if (r_auto_timer == AUTO_MAX) r_auto_timer <= '0;
        else                          r_auto_timer <= r_auto_timer + AUTO_W'(1);
      end
    end
  end

  assign auto_active = r_auto_active;
`else
  // Long presses of the next button are intentionally ignored in this build
  logic w_unused_next_long;
  assign w_unused_next_long = w_next_evt.long_evt;
  assign w_adv              = w_next_evt.short_evt;
  assign auto_active        = 1'b0;
`endif

  // Command registers; events arriving while ena is low are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat_sel   <= PAT_OFF;
      r_pause     <= 1'b0;
      r_speed_sel <= 1'b0;
    end else if (ena) begin
      if (w_adv)                r_pat_sel   <= r_pat_sel + 3'd1;
      if (w_mode_evt.short_evt) r_pause     <= ~r_pause;
      if (w_mode_evt.long_evt)  r_speed_sel <= ~r_speed_sel;
    end
  end

  assign pat_sel   = r_pat_sel;
  assign speed_sel = r_speed_sel;
  assign pause     = r_pause;

endmodule

// File: tb/tb_led_ctrl_button_sequencer.sv
// Self-checking bench for led_ctrl_button_sequencer (small timing parameters).
module tb_led_ctrl_button_sequencer;

  localparam int D = 4;
  localparam int L = 20;
  localparam int P = 10;
  localparam int NVEC = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       btn_next_raw;
  logic       btn_mode_raw;
  logic [2:0] pat_sel;
  logic       speed_sel;
  logic       pause;
  logic       auto_active;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the outputs should be once all presses have settled
  int m_pat;
  int m_pause;
  int m_speed;

  typedef struct {
    int btn;    // bit0 = next, bit1 = mode, 0 = no press (idle only)
    int hold;
    bit en;
    int e_pat;
    int e_pause;
    int e_speed;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  led_ctrl_button_sequencer #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
`ifdef AUTO_CYCLE_EN
    ,
    .AUTO_PERIOD      (P)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .btn_next_raw(btn_next_raw),
    .btn_mode_raw(btn_mode_raw),
    .pat_sel     (pat_sel),
    .speed_sel   (speed_sel),
    .pause       (pause),
    .auto_active (auto_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press of the selected buttons for 'hold' cycles, then long enough idle to settle
  task automatic press(input int btn, input int hold);
    btn_next_raw = btn[0];
    btn_mode_raw = btn[1];
    cycles(hold);
    btn_next_raw = 1'b0;
    btn_mode_raw = 1'b0;
    cycles(D + 14);
  endtask

  // Behavioural effect of one settled press
  task automatic model_press(input int btn, input int hold, input bit en);
    bit is_long;
    is_long = (hold > L);
    if (!en) return;
    if (btn[0] && !is_long) m_pat = (m_pat + 1) % 8;
    if (btn[1]) begin
      if (is_long) m_speed = 1 - m_speed;
      else         m_pause = 1 - m_pause;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pat_sel"},   32'(pat_sel),   32'(m_pat));
    chk({tag, ".pause"},     32'(pause),     32'(m_pause));
    chk({tag, ".speed_sel"}, 32'(speed_sel), 32'(m_speed));
  endtask

  initial begin
    int btn;
    int hold;
    bit en;
    int prev;
    int changes;
    int gap;
    bit seen;

    rst = 1'b1; ena = 1'b1; btn_next_raw = 1'b0; btn_mode_raw = 1'b0;
    m_pat = 7; m_pause = 0; m_speed = 0;
    cycles(3);
    chk_model("reset");
    chk("reset.auto_active", 32'(auto_active), 32'd0);
    rst = 1'b0;
    cycles(3);

    // Directed table: wrap sequence, pause/speed, ena drop, no replay
    for (int i = 0; i < 9; i++) vecs[i] = '{1, 10, 1'b1, i % 8, 0, 0};
    vecs[9]  = '{2, 10, 1'b1, 0, 1, 0};
    vecs[10] = '{2, 30, 1'b1, 0, 1, 1};
    vecs[11] = '{1, 10, 1'b0, 0, 1, 1};
    vecs[12] = '{0, 10, 1'b1, 0, 1, 1};
    for (int i = 0; i < NVEC; i++) begin
      ena = vecs[i].en;
      press(vecs[i].btn, vecs[i].hold);
      ena = 1'b1;
      chk($sformatf("vec%0d.pat_sel", i),   32'(pat_sel),   32'(vecs[i].e_pat));
      chk($sformatf("vec%0d.pause", i),     32'(pause),     32'(vecs[i].e_pause));
      chk($sformatf("vec%0d.speed_sel", i), 32'(speed_sel), 32'(vecs[i].e_speed));
    end
    m_pat = 0; m_pause = 1; m_speed = 1;

    // Long mode press: speed toggles while still held, release changes nothing
    btn_mode_raw = 1'b1;
    cycles(36);
    m_speed = 0;
    chk("long_held.speed_sel", 32'(speed_sel), 32'(m_speed));
    chk("long_held.pause",     32'(pause),     32'(m_pause));
    cycles(8);
    btn_mode_raw = 1'b0;
    cycles(D + 14);
    chk_model("long_release");

    // Bounce: runs of 2 cycles never survive the debouncer, nor does a 3-cycle hold
    for (int s = 0; s < 15; s++) begin
      btn_next_raw = s[0];
      cycles(2);
    end
    btn_next_raw = 1'b1;
    cycles(3);
    btn_next_raw = 1'b0;
    cycles(D + 14);
    chk_model("bounce");

`ifndef AUTO_CYCLE_EN
    // Long next press has no effect in the default build
    press(1, 30);
    chk_model("next_long");
    chk("next_long.auto_active", 32'(auto_active), 32'd0);
`endif

    // Randomised presses against the reference model
    for (int i = 0; i < 30; i++) begin
      btn  = $urandom_range(1, 3);
      hold = ($urandom_range(0, 1) == 1) ? $urandom_range(26, 36) : $urandom_range(7, 14);
`ifdef AUTO_CYCLE_EN
      if (btn[0] && hold > L) hold = $urandom_range(7, 14);
`endif
      en = ($urandom_range(0, 3) != 0);
      ena = en;
      press(btn, hold);
      ena = 1'b1;
      model_press(btn, hold, en);
      chk_model($sformatf("rand%0d", i));
      chk($sformatf("rand%0d.auto_active", i), 32'(auto_active), 32'd0);
    end

    // Asynchronous reset mid-run, with the next button held
    btn_next_raw = 1'b1;
    cycles(5);
    rst = 1'b1;
    #1;
    m_pat = 7; m_pause = 0; m_speed = 0;
    chk_model("midrst");
    chk("midrst.auto_active", 32'(auto_active), 32'd0);
    cycles(2);
    btn_next_raw = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(D + 10);
    press(1, 10);
    m_pat = 0;
    chk_model("after_rst");

`ifdef AUTO_CYCLE_EN
    // Auto cycling: about one advance per period while running
    press(1, 30);
    chk("auto_on.auto_active", 32'(auto_active), 32'd1);
    changes = 0;
    prev = pat_sel;
    for (int c = 0; c < 100; c++) begin
      cycles(1);
      if (int'(pat_sel) != prev) changes++;
      prev = pat_sel;
    end
    chk("auto_rate.in_range", 32'(changes >= 9 && changes <= 11), 32'd1);
    // Pause freezes the timer
    btn_mode_raw = 1'b1;
    cycles(10);
    btn_mode_raw = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cycles(1);
      if (pause) seen = 1'b1;
    end
    chk("auto_pause.pause", 32'(pause), 32'd1);
    prev = pat_sel;
    cycles(50);
    chk("auto_pause.frozen", 32'(pat_sel), 32'(prev));
    // Manual short while paused advances and clears the timer
    press(1, 10);
    chk("auto_manual.pat_sel", 32'(pat_sel), 32'((prev + 1) % 8));
    prev = pat_sel;
    btn_mode_raw = 1'b1;
    cycles(10);
    btn_mode_raw = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cycles(1);
      if (!pause) seen = 1'b1;
    end
    chk("auto_unpause.pause", 32'(pause), 32'd0);
    gap = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cycles(1);
      gap++;
      if (int'(pat_sel) != prev) seen = 1'b1;
    end
    chk("auto_after_clear.gap_ok", 32'(seen && gap >= P - 1 && gap <= P + 1), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
